// File: rtl/uint_sub_pkg.sv
// Shared definitions for the shared-subtractor arbiter: default sizes,
// ID-width helper and the default-sized result record.
package uint_sub_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  // Requester ID width; never narrower than one bit.
  function automatic int idw_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IDW = idw_f(DEF_NREQ);

  // Result record for the default configuration.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] O;
    logic                 borrow;
    logic [DEF_IDW-1:0]   id;
  } sub_rsp_t;

endpackage

// File: rtl/coreir_sub.sv
// Plain unsigned subtractor datapath: out = in0 - in1 (mod 2^width).
module coreir_sub #(
  parameter int width = 16
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic [width-1:0] out
);

  assign out = in0 - in1;

endmodule

// File: rtl/uint_sub_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter. The search starts at ptr and wraps;
// the pointer itself lives in the parent so idle cycles never rotate it.
module rr_arbiter
  import uint_sub_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic found;
  int   idx;

  // First valid request in order ptr, ptr+1, ..., wrapping; grant gated by en.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant_idx  = IDW'(idx);
        grant[idx] = en;
      end
    end
  end

endmodule

// File: rtl/uint_sub_arbiter.sv
// Shares a single WIDTH-bit unsigned subtractor among NREQ requesters.
// Round-robin grant, one registered result stage with valid/ready.
module uint_sub_arbiter
  import uint_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = idw_f(NREQ)
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_O,
  output logic                  rsp_borrow,
  output logic [IDW-1:0]        rsp_id
);

  typedef struct packed {
    logic [WIDTH-1:0] O;
    logic             borrow;
    logic [IDW-1:0]   id;
  } rsp_t;

  logic [NREQ-1:0][WIDTH-1:0] a_lane, b_lane;
  logic [NREQ-1:0][WIDTH-1:0] a_msk, b_msk;
  logic [WIDTH-1:0]           a_sel, b_sel;
  logic [WIDTH:0]             diff;
  logic [NREQ-1:0]            grant;
  logic [IDW-1:0]             grant_idx;
  logic [IDW-1:0]             ptr, ptr_nxt;
  logic                       can_accept, xfer;
  logic                       rsp_vld;
  rsp_t                       rsp_q;

  // Flat operand buses already use lane-major packing.
  assign a_lane = req_a;
  assign b_lane = req_b;

  // Output slot is free when empty or being drained this cycle.
  // Reset forces the grant off so nothing is acknowledged while held in reset.
  assign can_accept = (!rsp_vld || rsp_ready) && ASYNCRESETN;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // Per-lane operand masking; grant is one-hot so OR-ing the lanes is a mux.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign a_msk[i] = a_lane[i] & {WIDTH{grant[i]}};
    assign b_msk[i] = b_lane[i] & {WIDTH{grant[i]}};
  end

  // OR-reduce the masked lanes into the shared subtractor inputs.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel = a_sel | a_msk[i];
      b_sel = b_sel | b_msk[i];
    end
  end

  // Zero-extended by one bit: the top bit of the difference is the
  // inverted carry-out, i.e. set exactly when a < b.
  coreir_sub #(.width(WIDTH + 1)) u_sub (
    .in0 ({1'b0, a_sel}),
    .in1 ({1'b0, b_sel}),
    .out (diff)
  );

  assign ptr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Result register and rotation pointer; data holds when nothing transfers.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      rsp_q   <= '0;
      rsp_vld <= 1'b0;
      ptr     <= '0;
    end else if (xfer) begin
      rsp_q.O      <= diff[WIDTH-1:0];
      rsp_q.borrow <= diff[WIDTH];
      rsp_q.id     <= grant_idx;
      rsp_vld      <= 1'b1;
      ptr          <= ptr_nxt;
    end else if (rsp_ready) begin
      rsp_vld <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_vld;
  assign rsp_O      = rsp_q.O;
  assign rsp_borrow = rsp_q.borrow;
  assign rsp_id     = rsp_q.id;

endmodule

// File: tb/tb_uint_sub_arbiter.sv
// Bench for uint_sub_arbiter: behavioural model + per-cycle compare,
// plus directed literal expectations.
module tb_uint_sub_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int I = 2;

  logic           CLK;
  logic           ASYNCRESETN;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_O;
  logic           rsp_borrow;
  logic [I-1:0]   rsp_id;

  uint_sub_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_O       (rsp_O),
    .rsp_borrow  (rsp_borrow),
    .rsp_id      (rsp_id)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit       m_valid;
  int       m_O, m_borrow, m_id, m_ptr;

  // Which requester (or -1) wins given the model state and current inputs.
  function automatic int winner();
    if (!ASYNCRESETN) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge CLK or negedge ASYNCRESETN) begin
    int w, a, b;
    if (!ASYNCRESETN) begin
      m_valid = 0; m_O = 0; m_borrow = 0; m_id = 0; m_ptr = 0;
    end else begin
      w = winner();
      if (w >= 0) begin
        a = int'(req_a[w*W +: W]);
        b = int'(req_b[w*W +: W]);
        m_O      = (a - b + 256) % 256;
        m_borrow = (a < b) ? 1 : 0;
        m_id     = w;
        m_valid  = 1;
        m_ptr    = (w + 1) % N;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    int w;
    logic [N-1:0] er;
    w = winner();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("cmp_req_ready", 32'(req_ready), 32'(er));
    chk("cmp_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("cmp_rsp_O", 32'(rsp_O), 32'(m_O));
    chk("cmp_rsp_borrow", 32'(rsp_borrow), 32'(m_borrow));
    chk("cmp_rsp_id", 32'(rsp_id), 32'(m_id));
  end

  // ---------------- stimulus ----------------
  task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic drv_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc_neg();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  logic [N-1:0] vt [12] = '{4'b1111, 4'b0101, 4'b1010, 4'b0000, 4'b1001, 4'b0110,
                            4'b1111, 4'b0011, 4'b1100, 4'b1111, 4'b0001, 4'b1111};
  logic         rt [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                            1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [W-1:0] ta [8] = '{8'h00, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'hA5, 8'h10};
  logic [W-1:0] tb [8] = '{8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h02, 8'h5A, 8'h10};

  initial begin
    ASYNCRESETN = 1'b0;
    req_valid   = '1;
    rsp_ready   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    for (int i = 0; i < N; i++) set_lane(i, W'(8'h30 + i), W'(8'h10 * i));

    // Reset held with every requester valid.
    @(negedge CLK);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_O", 32'(rsp_O), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);

    // Release: grant goes to requester 0, then strict rotation, one per cycle.
    drv_edge();
    ASYNCRESETN = 1'b1;
    rsp_ready   = 1'b1;
    @(negedge CLK);
    chk("rel_grant0", 32'(req_ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      cyc_neg();
      chk("rr_valid", 32'(rsp_valid), 32'h1);
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
    end

    // Single requester 2: 0x05-0x07 then 0xFF-0x01.
    drv_edge();
    req_valid = 4'b0100;
    set_lane(2, 8'h05, 8'h07);
    @(negedge CLK);
    chk("single_ready", 32'(req_ready), 32'b0100);
    drv_edge();
    set_lane(2, 8'hFF, 8'h01);
    @(negedge CLK);
    chk("sub_5_7_O", 32'(rsp_O), 32'hFE);
    chk("sub_5_7_borrow", 32'(rsp_borrow), 32'h1);
    chk("sub_5_7_id", 32'(rsp_id), 32'h2);
    cyc_neg();
    chk("sub_ff_1_O", 32'(rsp_O), 32'hFE);
    chk("sub_ff_1_borrow", 32'(rsp_borrow), 32'h0);

    // Backpressure for 3 cycles, then release with no bubble (ptr=3 now).
    drv_edge();
    rsp_ready = 1'b0;
    req_valid = 4'b1011;
    set_lane(3, 8'h09, 8'h03);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) cyc_neg(); else @(negedge CLK);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_O", 32'(rsp_O), 32'hFE);
      chk("bp_id", 32'(rsp_id), 32'h2);
    end
    drv_edge();
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_release_ready", 32'(req_ready), 32'b1000);
    cyc_neg();
    chk("bp_nobubble_valid", 32'(rsp_valid), 32'h1);
    chk("bp_nobubble_id", 32'(rsp_id), 32'h3);
    chk("bp_nobubble_O", 32'(rsp_O), 32'h06);

    // Pointer hold: req 0 taken on this edge, then req 1, two idle cycles,
    // then reqs 0 and 3: ptr=2 so 3 wins before 0.
    drv_edge();
    req_valid = 4'b0010;
    @(negedge CLK);
    chk("ph_grant1", 32'(req_ready), 32'b0010);
    drv_edge();
    req_valid = 4'b0000;
    drv_edge();
    drv_edge();
    req_valid = 4'b1001;
    @(negedge CLK);
    chk("ph_grant3_first", 32'(req_ready), 32'b1000);
    cyc_neg();
    chk("ph_id3", 32'(rsp_id), 32'h3);
    chk("ph_grant0_next", 32'(req_ready), 32'b0001);
    drv_edge();
    req_valid = 4'b0000;
    @(negedge CLK);
    chk("ph_id0", 32'(rsp_id), 32'h0);

    // Directed table of valid/ready patterns and boundary operands.
    for (int k = 0; k < 12; k++) begin
      drv_edge();
      req_valid = vt[k];
      rsp_ready = rt[k];
      for (int i = 0; i < N; i++) set_lane(i, ta[(k + i) % 8], tb[(k * 3 + i) % 8]);
    end

    // Drain, then reset while a result is held under backpressure.
    drv_edge();
    req_valid = '0;
    rsp_ready = 1'b1;
    drv_edge();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    set_lane(1, 8'h40, 8'h41);
    drv_edge();
    chk("mr_held_valid", 32'(rsp_valid), 32'h1);
    chk("mr_held_O", 32'(rsp_O), 32'hFF);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("mr_valid_drop", 32'(rsp_valid), 32'h0);
    chk("mr_O_clear", 32'(rsp_O), 32'h0);
    drv_edge();
    ASYNCRESETN = 1'b1;
    req_valid   = 4'b1111;
    rsp_ready   = 1'b1;
    @(negedge CLK);
    chk("mr_ptr0_grant", 32'(req_ready), 32'b0001);
    cyc_neg();
    chk("mr_first_id", 32'(rsp_id), 32'h0);
    cyc_neg();
    chk("mr_second_id", 32'(rsp_id), 32'h1);

    drv_edge();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uint_sub_arbiter.md
# uint_sub_arbiter

Shares one `WIDTH`-bit unsigned subtractor among `NREQ` requesters. Each requester presents an operand pair under a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the difference, borrow flag and requester ID are registered into a single output stage with its own valid/ready handshake. The block sits between operand-producing clients and the single `coreir_sub` datapath instance, so the design carries one subtractor instead of `NREQ`.

## Interface
Parameters:
- `WIDTH`, 8, operand and result width in bits (≥1).
- `NREQ`, 4, number of requesters (2..16).
- `IDW`, `max(1, clog2(NREQ))`, derived; width of `rsp_id`.

Ports:
- `CLK`  in  1  single clock, all state on rising edge.
- `ASYNCRESETN`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  `NREQ`  bit i: requester i presents operands.
- `req_ready`  out  `NREQ`  bit i: requester i's operands are accepted this cycle; one-hot or zero.
- `req_a`  in  `NREQ*WIDTH`  minuend; requester i at bits `[i*WIDTH +: WIDTH]`.
- `req_b`  in  `NREQ*WIDTH`  subtrahend; same packing as `req_a`.
- `rsp_valid`  out  1  result register holds a result.
- `rsp_ready`  in  1  consumer takes the result this cycle.
- `rsp_O`  out  `WIDTH`  `(a - b) mod 2^WIDTH`.
- `rsp_borrow`  out  1  1 when `a < b`, unsigned.
- `rsp_id`  out  `IDW`  index of the granted requester.

## Operation
- `can_accept = !rsp_valid || rsp_ready`, i.e. the output register is empty or is being drained this cycle.
- Arbiter: rotating priority starting at pointer `ptr`. The winner is the first i in order `ptr, ptr+1, …, NREQ-1, 0, …` with `req_valid[i]=1`.
- Grant: `req_ready[winner] = can_accept`; all other bits are 0. `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
- Transfer on requester i occurs when `req_valid[i] && req_ready[i]`. On that edge:
  - `rsp_O` ← `a_i - b_i` (computed by the shared subtractor)
  - `rsp_borrow` ← `a_i < b_i`
  - `rsp_id` ← i
  - `rsp_valid` ← 1
  - `ptr` ← `(i+1) mod NREQ`
- No transfer and `rsp_ready=1` → `rsp_valid` ← 0; the data registers hold their value.
- `ptr` changes only on a transfer. An idle cycle does not rotate it.
- While `rsp_valid && !rsp_ready`, `rsp_O`, `rsp_borrow` and `rsp_id` are stable and `req_ready` is all-zero.
- A requester must hold `req_valid` and its operands until accepted. The arbiter does not lock a grant, so the winner may change between cycles if the valid set changes.
- Arithmetic: both operands are zero-extended to `WIDTH+1` bits. `rsp_O` is the low `WIDTH` bits of the difference; `rsp_borrow` is the inverted carry-out (1 exactly when `a < b`).

## Timing
- Reset (`ASYNCRESETN`=0, takes effect immediately):
  - `rsp_valid`=0, `rsp_O`=0, `rsp_borrow`=0, `rsp_id`=0, `ptr`=0.
  - `req_ready` is forced to all-zero while reset is asserted.
- Latency: 1 cycle. A transfer at edge k gives `rsp_valid`=1 in the cycle after edge k.
- Throughput: 1 result per cycle when `rsp_ready` is held at 1.
- Fairness: a continuously valid requester is granted within `NREQ` transfers.
- Simultaneous drain and accept (`rsp_valid && rsp_ready` plus a new transfer): the register is overwritten with the new result and `rsp_valid` stays 1, with no bubble.
- Reset mid-operation: any pending result is discarded without handshake. Requesters re-present after reset is released.
- Deassertion of `ASYNCRESETN` is synchronised externally. The first transfer can occur on the first edge after release.

## Structure
- Shared package `uint_sub_pkg`:
  - `IDW` computation function (`clog2` with minimum 1).
  - Default `WIDTH`/`NREQ` constants.
  - Packed result struct `{O, borrow, id}`.
- Sub-module `rr_arbiter` (params `NREQ`): inputs `req`, `ptr`, `en`; outputs `grant` (one-hot) and `grant_idx`. It is purely combinational; `ptr` is kept in the parent.
- Datapath: one `coreir_sub` instance with `width=WIDTH+1`, fed by a one-hot mux of the operands selected by `grant`.
- Output register with async active-low reset in the parent.

## Test plan
- Reset: hold `ASYNCRESETN`=0 with all `req_valid`=1. Required: `req_ready`=0000 and all outputs 0. Release reset: grant goes to requester 0.
- Single requester, WIDTH=8: req 2, a=0x05, b=0x07, `rsp_ready`=1. Next cycle: `rsp_O`=0xFE, `rsp_borrow`=1, `rsp_id`=2. Also a=0xFF, b=0x01 → `rsp_O`=0xFE, `rsp_borrow`=0.
- All four requesters valid continuously, `rsp_ready`=1:
  - `rsp_id` sequence is 0,1,2,3,0,… with one result every cycle.
  - No requester waits more than 4 transfers.
- Backpressure: `rsp_ready`=0 for 3 cycles with a result held. Required:
  - Outputs stable and `req_ready`=0000 throughout.
  - On the `rsp_ready`=1 cycle, a new transfer is accepted in the same cycle with no bubble.
- Pointer hold: grant req 1, then 2 idle cycles, then reqs 0 and 3 valid. Required: req 3 is granted first (`ptr`=2, rotation order 2,3,0), then req 0.
- Reset mid-operation: assert `ASYNCRESETN`=0 while `rsp_valid`=1 and `rsp_ready`=0. Required: `rsp_valid` drops immediately and `ptr` returns to 0.
